par_mode_sequencer: RTL and testbench

// - Timed mode controller that sits upstream of the Par-indexed datapath.
// - Drives the partition index mode: 0 = L; 1 and 2 = H.
//   Par[0]=L, Par[1]=H, Par[2]=H.
// - Steps L -> H1 -> H2 -> L, spending PERIOD enabled cycles in each state.
// - Admits level-tagged requests into a one-entry output buffer. Data is

---
 rtl/par_mode_sequencer.sv | 123 ++++++++++++
 tb/tb_par_mode_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/par_mode_sequencer.sv
// par_mode_sequencer
// Timed mode controller for the Par-indexed datapath. The mode steps
// L(0) -> H1(1) -> H2(2) -> L, spending PERIOD enabled cycles in each mode.
// Level-tagged requests are admitted into a one-entry output buffer only in
// modes allowed for their level. H data still buffered when H2 returns to L
// is scrubbed, so it never reaches the L side.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   en                    run enable; 0 freezes the timer and blocks intake
//   req_valid/req_ready   request handshake; req_lvl (0=L,1=H), req_data
//   out_valid/out_ready   output buffer handshake; out_data, out_lvl
//   mode, mode_is_high    current Par index and (mode != 0)
//   switch_pulse          one cycle after every mode change
//   flush_pulse           one cycle after H data is dropped at H2->L
module par_mode_sequencer #(
   parameter int PERIOD = 10,
   parameter int CNT_W  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_lvl,
   input  logic [DATA_W-1:0] req_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_lvl,
   output logic [1:0]        mode,
   output logic              mode_is_high,
   output logic              switch_pulse,
   output logic              flush_pulse
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   typedef enum logic [1:0] {
      M_L   = 2'd0,
      M_H1  = 2'd1,
      M_H2  = 2'd2,
      M_BAD = 2'd3
   } mode_t;

   mode_t             mode_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic              lvl_p1;

   logic last, wrap, guard, level_ok, push, pop, scrub;

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         M_L:     next_mode = M_H1;
         M_H1:    next_mode = M_H2;
         default: next_mode = M_L;
      endcase
   endfunction

   assign last     = (cnt_q == LAST);
   assign wrap     = en && last && (mode_q != M_BAD);
   // The final H2 cycle takes no new data, so a push can never collide
   // with the scrub that happens on the same edge.
   assign guard    = ((mode_q == M_H2) && last) || (mode_q == M_BAD);
   assign level_ok = (mode_q != M_L) || !req_lvl;

   // Gated by rst_n so that every output reads 0 while reset is held.
   assign req_ready = rst_n && en && (!vld_p1 || out_ready) && level_ok && !guard;
   assign push      = req_valid && req_ready;
   assign pop       = vld_p1 && out_ready;
   assign scrub     = wrap && (mode_q == M_H2) && vld_p1 && lvl_p1;

   assign mode         = mode_q;
   assign mode_is_high = (mode_q != M_L);
   assign out_valid    = vld_p1;
   assign out_data     = data_p1;
   assign out_lvl      = lvl_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q       <= M_L;
         cnt_q        <= '0;
         switch_pulse <= 1'b0;
         flush_pulse  <= 1'b0;
         vld_p1       <= 1'b0;
         data_p1      <= '0;
         lvl_p1       <= 1'b0;
      end else begin
         // timer / mode stage
         if (mode_q == M_BAD) begin
            mode_q <= M_L;
            cnt_q  <= '0;
         end else if (en) begin
            if (last) begin
               cnt_q  <= '0;
               mode_q <= next_mode(mode_q);
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         switch_pulse <= wrap;
         flush_pulse  <= scrub;

         // output buffer stage: scrub wins over pop/push; push replaces a
         // popped entry in the same cycle so there is no bubble
         if (scrub) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            lvl_p1  <= 1'b0;
         end else if (push) begin
            vld_p1  <= 1'b1;
            data_p1 <= req_data;
            lvl_p1  <= req_lvl;
         end else if (pop) begin
            vld_p1  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_par_mode_sequencer.sv
module tb_par_mode_sequencer;

   localparam int P = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_lvl = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_lvl;
   logic [1:0] mode;
   logic       mode_is_high;
   logic       switch_pulse;
   logic       flush_pulse;

   always #5 clk = ~clk;

   par_mode_sequencer #(.PERIOD(P), .CNT_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_ready(req_ready), .req_lvl(req_lvl), .req_data(req_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lvl(out_lvl),
      .mode(mode), .mode_is_high(mode_is_high),
      .switch_pulse(switch_pulse), .flush_pulse(flush_pulse)
   );

   int checks = 0;
   int errors = 0;

   // reference model: t counts enabled cycles within one 3*P period
   int         t;
   logic       m_vld, m_lvl, m_sw, m_fl;
   logic [7:0] m_data;
   logic [8:0] sbq[$];
   logic       rr_seen;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      t = 0; m_vld = 0; m_lvl = 0; m_sw = 0; m_fl = 0; m_data = 8'h00;
      sbq.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_mode", 32'(mode), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_lvl", 32'(out_lvl), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_high", 32'(mode_is_high), 0);
      chk("rst_sw", 32'(switch_pulse), 0);
      chk("rst_fl", 32'(flush_pulse), 0);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // one clock cycle: drive at negedge, compare against the model, let the
   // edge happen, then advance the model
   task automatic cyc(input logic e, input logic rv, input logic lv,
                      input logic [7:0] d, input logic ordy);
      int   mm, mc;
      logic guard, exp_rr, acc, scrub;
      logic [8:0] ent;
      @(negedge clk);
      en = e; req_valid = rv; req_lvl = lv; req_data = d; out_ready = ordy;
      #1;
      mm = (t / P) % 3;
      mc = t % P;
      guard  = (mm == 2) && (mc == P - 1);
      exp_rr = e && (!m_vld || ordy) && ((mm != 0) || !lv) && !guard;
      rr_seen = req_ready;
      chk("mode", 32'(mode), 32'(mm));
      chk("high", 32'(mode_is_high), 32'(mm != 0));
      chk("ready", 32'(req_ready), 32'(exp_rr));
      chk("valid", 32'(out_valid), 32'(m_vld));
      chk("data", 32'(out_data), 32'(m_data));
      chk("lvl", 32'(out_lvl), 32'(m_lvl));
      chk("switch", 32'(switch_pulse), 32'(m_sw));
      chk("flush", 32'(flush_pulse), 32'(m_fl));
      acc   = rv && exp_rr;
      scrub = e && guard && m_vld && m_lvl;
      if (scrub) begin
         if (sbq.size() > 0) ent = sbq.pop_front();
         m_vld = 0; m_data = 8'h00; m_lvl = 0;
      end else begin
         if (m_vld && ordy) begin
            if (sbq.size() == 0) chk("sb_empty", 1, 0);
            else begin
               ent = sbq.pop_front();
               chk("sb_pop", {23'd0, out_lvl, out_data}, 32'(ent));
            end
            m_vld = 0;
         end
         if (acc) begin
            sbq.push_back({lv, d});
            m_vld = 1; m_data = d; m_lvl = lv;
         end
      end
      m_fl = scrub;
      m_sw = e && (mc == P - 1);
      if (e) t = (t + 1) % (3 * P);
      @(posedge clk);
   endtask

   initial begin
      model_reset();

      // free run from reset: 10 cycles per mode, pulses at 10/20/30
      do_reset();
      #1;
      chk("t1_mode0", 32'(mode), 0);
      for (int k = 1; k <= 30; k++) begin
         cyc(1, 0, 0, 8'h00, 1);
         #1;
         chk("t1_mode", 32'(mode), (k < 10) ? 0 : (k < 20) ? 1 : (k < 30) ? 2 : 0);
         chk("t1_sw", 32'(switch_pulse), 32'(k == 10 || k == 20 || k == 30));
      end

      // en low for 5 cycles at cnt=4 delays L->H1 by 5 cycles
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 8'h00, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 8'h00, 1);
      #1 chk("t2_hold", 32'(mode), 0);
      for (int k = 0; k < 5; k++) cyc(1, 0, 0, 8'h00, 1);
      #1 chk("t2_still_l", 32'(mode), 0);
      cyc(1, 0, 0, 8'h00, 1);
      #1;
      chk("t2_h1", 32'(mode), 1);
      chk("t2_sw", 32'(switch_pulse), 1);

      // H request blocked throughout L, accepted once in H1
      do_reset();
      for (int k = 0; k < 10; k++) begin
         cyc(1, 1, 1, 8'h3C, 1);
         chk("t3_block", 32'(rr_seen), 0);
      end
      cyc(1, 1, 1, 8'h3C, 1);
      chk("t3_accept", 32'(rr_seen), 1);
      #1;
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_data", 32'(out_data), 32'h3C);
      cyc(1, 0, 0, 8'h00, 1);

      // H data stalled across H2->L is scrubbed
      do_reset();
      for (int k = 0; k < 25; k++) cyc(1, 0, 0, 8'h00, 1);
      cyc(1, 1, 1, 8'hA5, 0);
      chk("t4_accept", 32'(rr_seen), 1);
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 8'h00, 0);
      #1;
      chk("t4_valid", 32'(out_valid), 0);
      chk("t4_data", 32'(out_data), 0);
      chk("t4_flush", 32'(flush_pulse), 1);
      chk("t4_mode", 32'(mode), 0);
      cyc(1, 0, 0, 8'h00, 1);
      #1 chk("t4_flush_end", 32'(flush_pulse), 0);

      // back-to-back L requests, no bubble
      do_reset();
      cyc(1, 1, 0, 8'h11, 1);
      chk("t5_acc1", 32'(rr_seen), 1);
      #1 chk("t5_d1", 32'(out_data), 32'h11);
      cyc(1, 1, 0, 8'h22, 1);
      chk("t5_acc2", 32'(rr_seen), 1);
      #1;
      chk("t5_d2", 32'(out_data), 32'h22);
      chk("t5_v2", 32'(out_valid), 1);
      cyc(1, 0, 0, 8'h00, 1);

      // guard cycle: last H2 cycle refuses, next L cycle accepts
      do_reset();
      for (int k = 0; k < 29; k++) cyc(1, 0, 0, 8'h00, 1);
      cyc(1, 1, 0, 8'h5A, 1);
      chk("t6_guard", 32'(rr_seen), 0);
      cyc(1, 1, 0, 8'h5A, 1);
      chk("t6_accept", 32'(rr_seen), 1);
      #1;
      chk("t6_data", 32'(out_data), 32'h5A);
      chk("t6_mode", 32'(mode), 0);

      // random traffic with one mid-run reset
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if (k == 200) do_reset();
         cyc(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
             8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
